// File: rtl/encoder_pkg.sv
// Shared definitions for the 4-to-2 priority encoder: index type,
// per-request-line index constants and a request-counting helper.
package encoder_pkg;

    // Width of the request vector {d, c, b, a}
    localparam int REQ_W = 4;

    // Encoded index of a request line
    typedef logic [1:0] enc_idx_t;

    // Fixed code for each request line, independent of priority order
    localparam enc_idx_t IDX_A = 2'b00;
    localparam enc_idx_t IDX_B = 2'b01;
    localparam enc_idx_t IDX_C = 2'b10;
    localparam enc_idx_t IDX_D = 2'b11;

    // Number of active request lines; drives the multi-hot flag
    function automatic logic [2:0] req_count(input logic [REQ_W-1:0] req);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < REQ_W; i++) begin
            cnt = cnt + {2'b00, req[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/encoder_core.sv
// Combinational core of the priority encoder. Produces the index of the
// highest-priority active line plus valid and multi-hot flags. Priority
// direction is chosen at elaboration time by PRIORITY_HIGH_D.
module encoder_core
    import encoder_pkg::*;
#(
    parameter bit PRIORITY_HIGH_D = 1'b1
) (
    input  logic     a,
    input  logic     b,
    input  logic     c,
    input  logic     d,
    output enc_idx_t idx,
    output logic     valid,
    output logic     multi
);

    logic [REQ_W-1:0] req;

    assign req = {d, c, b, a};

    // Priority selection; with no request active the index falls back to 00
    always_comb begin
        idx = IDX_A;
        if (PRIORITY_HIGH_D) begin
            if (d) begin
                idx = IDX_D;
            end else if (c) begin
                idx = IDX_C;
            end else if (b) begin
                idx = IDX_B;
            end else begin
                idx = IDX_A;
            end
        end else begin
            if (a) begin
                idx = IDX_A;
            end else if (b) begin
                idx = IDX_B;
            end else if (c) begin
                idx = IDX_C;
            end else if (d) begin
                idx = IDX_D;
            end else begin
                idx = IDX_A;
            end
        end
    end

    // Qualifier flags: any request active, and two or more active
    always_comb begin
        valid = |req;
        multi = (req_count(req) >= 3'd2);
    end

endmodule

// File: rtl/encoder.sv
// Top level of the 4-to-2 priority encoder. Wraps the combinational core
// with either a one-cycle output register (REGISTERED=1) or a direct
// bypass (REGISTERED=0), in which case clk, rst_n and en are ignored.
module encoder
    import encoder_pkg::*;
#(
    parameter bit REGISTERED      = 1'b1,
    parameter bit PRIORITY_HIGH_D = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic x,
    output logic y,
    output logic valid,
    output logic multi
);

    enc_idx_t core_idx;
    logic     core_valid;
    logic     core_multi;

    encoder_core #(
        .PRIORITY_HIGH_D (PRIORITY_HIGH_D)
    ) u_core (
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .idx   (core_idx),
        .valid (core_valid),
        .multi (core_multi)
    );

    if (REGISTERED) begin : g_reg

        enc_idx_t idx_d;
        enc_idx_t idx_q;
        logic     valid_d;
        logic     valid_q;
        logic     multi_d;
        logic     multi_q;

        // Capture the core result when enabled, otherwise hold
        always_comb begin
            idx_d   = idx_q;
            valid_d = valid_q;
            multi_d = multi_q;
            if (en) begin
                idx_d   = core_idx;
                valid_d = core_valid;
                multi_d = core_multi;
            end
        end

        // Output register; reset clears everything immediately so no stale index survives
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                idx_q   <= IDX_A;
                valid_q <= 1'b0;
                multi_q <= 1'b0;
            end else begin
                idx_q   <= idx_d;
                valid_q <= valid_d;
                multi_q <= multi_d;
            end
        end

        assign x     = idx_q[1];
        assign y     = idx_q[0];
        assign valid = valid_q;
        assign multi = multi_q;

    end else begin : g_bypass

        // Clock, reset and enable have no role on the bypass path
        logic unused_bypass;
        assign unused_bypass = &{1'b0, clk, rst_n, en};

        assign x     = core_idx[1];
        assign y     = core_idx[0];
        assign valid = core_valid;
        assign multi = core_multi;

    end

endmodule

// File: tb/tb_encoder.sv
// Self-checking bench for the encoder. Three instances: registered with
// d-highest priority, combinational with d-highest, combinational with
// a-highest. Expected {x,y,valid,multi} values are queued when stimulus is
// driven and popped when the corresponding output is sampled.
module tb_encoder;

    logic clk;
    logic rrst_n, ren, ra, rb, rc, rd;
    logic rx, ry, rvalid, rmulti;

    logic combRst_n, ca, cb, cc, cd;
    logic hx, hy, hvalid, hmulti;
    logic lx, ly, lvalid, lmulti;

    int nChecks;
    int nFails;

    logic [3:0] expQ[$];
    int         unitQ[$];
    string      tagQ[$];

    encoder #(.REGISTERED(1'b1), .PRIORITY_HIGH_D(1'b1)) dutReg (
        .clk(clk), .rst_n(rrst_n), .en(ren),
        .a(ra), .b(rb), .c(rc), .d(rd),
        .x(rx), .y(ry), .valid(rvalid), .multi(rmulti)
    );

    encoder #(.REGISTERED(1'b0), .PRIORITY_HIGH_D(1'b1)) dutCombHi (
        .clk(clk), .rst_n(combRst_n), .en(1'b0),
        .a(ca), .b(cb), .c(cc), .d(cd),
        .x(hx), .y(hy), .valid(hvalid), .multi(hmulti)
    );

    encoder #(.REGISTERED(1'b0), .PRIORITY_HIGH_D(1'b0)) dutCombLo (
        .clk(clk), .rst_n(combRst_n), .en(1'b1),
        .a(ca), .b(cb), .c(cc), .d(cd),
        .x(lx), .y(ly), .valid(lvalid), .multi(lmulti)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: scan request lines in priority order; returns {idx, valid, multi}
    function automatic logic [3:0] refModel(input logic [3:0] req, input bit highD);
        int cnt;
        int winner;
        cnt    = 0;
        winner = 0;
        for (int i = 0; i < 4; i++) begin
            if (req[i]) cnt++;
        end
        if (highD) begin
            for (int i = 0; i < 4; i++) if (req[i]) winner = i;
        end else begin
            for (int i = 3; i >= 0; i--) if (req[i]) winner = i;
        end
        return {winner[1:0], (cnt > 0), (cnt > 1)};
    endfunction

    // unit 0 = registered, 1 = combinational d-high, 2 = combinational a-high
    task automatic applyStimulus(input bit toReg, input logic a, input logic b,
                                 input logic c, input logic d);
        if (toReg) begin
            ra = a; rb = b; rc = c; rd = d;
        end else begin
            ca = a; cb = b; cc = c; cd = d;
        end
    endtask

    task automatic pushExp(input string tag, input int unit, input logic [3:0] exp);
        tagQ.push_back(tag);
        unitQ.push_back(unit);
        expQ.push_back(exp);
    endtask

    task automatic checkOutput();
        logic [3:0] observed;
        logic [3:0] expected;
        string      tag;
        int         unit;
        nChecks++;
        if (expQ.size() == 0) begin
            nFails++;
            $error("[TB] FAIL scoreboard_underflow observed=empty expected=entry");
        end else begin
            tag      = tagQ.pop_front();
            unit     = unitQ.pop_front();
            expected = expQ.pop_front();
            case (unit)
                0:       observed = {rx, ry, rvalid, rmulti};
                1:       observed = {hx, hy, hvalid, hmulti};
                default: observed = {lx, ly, lvalid, lmulti};
            endcase
            assert (observed === expected) else begin
                nFails++;
                $error("[TB] FAIL %s unit=%0d observed={x,y,v,m}=%b expected=%b",
                       tag, unit, observed, expected);
            end
        end
    endtask

    // Wait for the capturing edge and compare the oldest pending expectation
    task automatic regStep();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [3:0] req;
        nChecks   = 0;
        nFails    = 0;
        rrst_n    = 1'b0;
        ren       = 1'b1;
        combRst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] combinational exhaustive sweep");
        for (int i = 0; i < 16; i++) begin
            req       = 4'(i);
            combRst_n = (i % 2 == 0);
            applyStimulus(1'b0, req[0], req[1], req[2], req[3]);
            pushExp("comb_sweep_hi", 1, refModel(req, 1'b1));
            pushExp("comb_sweep_lo", 2, refModel(req, 1'b0));
            #1;
            checkOutput();
            checkOutput();
        end

        $display("[TB] combinational directed vectors");
        combRst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pushExp("onehot_a", 1, 4'b0010);
        #1 checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        pushExp("onehot_b", 1, 4'b0110);
        #1 checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        pushExp("onehot_c", 1, 4'b1010);
        #1 checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pushExp("onehot_d", 1, 4'b1110);
        #1 checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pushExp("none_active", 1, 4'b0000);
        #1 checkOutput();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        pushExp("multi_ac_hi", 1, 4'b1011);
        #1 checkOutput();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        pushExp("multi_all_hi", 1, 4'b1111);
        #1 checkOutput();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        pushExp("multi_ad_lo", 2, 4'b0011);
        #1 checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        pushExp("multi_bc_lo", 2, 4'b0111);
        #1 checkOutput();

        $display("[TB] registered reset hold with d=1, en=1");
        repeat (3) begin
            @(posedge clk);
            #1;
            pushExp("reset_hold", 0, 4'b0000);
            checkOutput();
        end
        @(negedge clk);
        rrst_n = 1'b1;
        pushExp("first_capture", 0, 4'b1110);
        regStep();

        $display("[TB] registered latency");
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        pushExp("pre_edge_11", 0, 4'b1110);
        pushExp("lat_0010", 0, 4'b1010);
        #1 checkOutput();
        regStep();
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        pushExp("pre_edge_10", 0, 4'b1010);
        pushExp("lat_0100", 0, 4'b0110);
        #1 checkOutput();
        regStep();

        $display("[TB] registered enable hold");
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        pushExp("capture_0001", 0, 4'b1110);
        regStep();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ren = 1'b0;
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0);
            pushExp("en_low_hold", 0, 4'b1110);
            regStep();
        end
        @(negedge clk);
        ren = 1'b1;
        pushExp("en_resume_1000", 0, 4'b0010);
        regStep();

        $display("[TB] asynchronous reset mid-cycle");
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        pushExp("pre_async_11", 0, 4'b1110);
        regStep();
        #2;
        rrst_n = 1'b0;
        #1;
        pushExp("async_clear", 0, 4'b0000);
        checkOutput();
        @(posedge clk);
        #1;
        pushExp("async_held", 0, 4'b0000);
        checkOutput();
        @(negedge clk);
        rrst_n = 1'b1;
        pushExp("post_reset_capture", 0, 4'b1110);
        regStep();

        $display("[TB] registered multi-hot and idle");
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        pushExp("reg_multi_all", 0, 4'b1111);
        regStep();
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pushExp("reg_idle", 0, 4'b0000);
        regStep();

        nChecks++;
        assert (expQ.size() == 0) else begin
            nFails++;
            $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
